// File: rtl/out_stage_pkg.sv
// Purpose: shared state encoding and default sizing for the PWM output stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package out_stage_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   localparam int NCH_DEF          = 7;
   localparam int SYNC_TIMEOUT_DEF = 255;
   localparam int TO_W_DEF         = 8;

endpackage

// File: rtl/out_commit_ctrl.sv
// Purpose: commit FSM - takes a config into shadow, commits it on sync or after a timeout.
// Latency: o_commit is combinational in the commit cycle; o_commit_pulse/o_timeout_flag one cycle later.
// Backpressure: o_cfg_ready is high only in IDLE; offers while PENDING are ignored.
module out_commit_ctrl
   import out_stage_pkg::*;
#(
   parameter int SYNC_TIMEOUT = SYNC_TIMEOUT_DEF,
   parameter int TO_W         = TO_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_cfg_valid,
   input  logic i_sync,
   output logic o_cfg_ready,
   output logic o_shadow_load,
   output logic o_commit,
   output logic o_commit_pulse,
   output logic o_timeout_flag
);

   // A zero timeout disables the forced commit; the counter then just parks at all-ones.
   localparam bit              TO_EN   = (SYNC_TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LAST = (SYNC_TIMEOUT == 0) ? {TO_W{1'b1}}
                                                             : TO_W'(SYNC_TIMEOUT - 1);
   localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

   state_t          r_state;
   state_t          w_state_nxt;
   logic [TO_W-1:0] r_cnt;
   logic            r_commit_pulse;
   logic            r_timeout_flag;
   logic            w_load;
   logic            w_commit;
   logic            w_forced;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state plus shadow-load / commit decisions; sync wins over timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_commit    = 1'b0;
      w_forced    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_cfg_valid) begin
               w_load      = 1'b1;
               w_state_nxt = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (i_sync) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (TO_EN && (r_cnt == TO_LAST)) begin
               w_commit    = 1'b1;
               w_forced    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Cycles spent in PENDING; cleared on capture, saturating so it can never wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          r_cnt <= '0;
      else if (w_load)                                  r_cnt <= '0;
      else if ((r_state == ST_PENDING) && (r_cnt != TO_LAST)) r_cnt <= r_cnt + CNT_ONE;
   end

   // Commit pulse and sticky timeout flag, aligned with the first cycle of the new config.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_commit_pulse <= 1'b0;
         r_timeout_flag <= 1'b0;
      end else begin
         r_commit_pulse <= w_commit;
         if (w_load)        r_timeout_flag <= 1'b0;
         else if (w_forced) r_timeout_flag <= 1'b1;
      end
   end

   assign o_cfg_ready    = (r_state == ST_IDLE);
   assign o_shadow_load  = w_load;
   assign o_commit       = w_commit;
   assign o_commit_pulse = r_commit_pulse;
   assign o_timeout_flag = r_timeout_flag;

endmodule

// File: rtl/pwm_out_stage.sv
// Purpose: NCH-channel pin stage, static/PWM select + inversion, config committed glitch-free at period start.
// Latency: 1 cycle from ovalues/pwm_dc to opins; a commit takes effect on opins at the commit edge.
// Backpressure: cfg_ready low while a config is pending. Optional fault forcing: OUT_STAGE_FAULT_EN.
module pwm_out_stage
   import out_stage_pkg::*;
#(
   parameter int NCH          = NCH_DEF,
   parameter int SYNC_TIMEOUT = SYNC_TIMEOUT_DEF,
   parameter int TO_W         = TO_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [NCH-1:0] cfg_sel_pwm,
   input  logic [NCH-1:0] cfg_invert,
   input  logic           sync,
   input  logic [NCH-1:0] ovalues,
   input  logic [NCH-1:0] pwm_dc,
   output logic [NCH-1:0] opins,
   output logic           commit_pulse,
`ifdef OUT_STAGE_FAULT_EN
   input  logic           fault,
   input  logic           fault_clr,
   output logic           fault_active,
`endif
   output logic           timeout_flag
);

   logic [NCH-1:0] r_shd_sel;
   logic [NCH-1:0] r_shd_inv;
   logic [NCH-1:0] r_act_sel;
   logic [NCH-1:0] r_act_inv;
   logic [NCH-1:0] r_opins;
   logic [NCH-1:0] w_sel;
   logic [NCH-1:0] w_inv;
   logic [NCH-1:0] w_mux;
   logic [NCH-1:0] w_opins_nxt;
   logic           w_shadow_load;
   logic           w_commit;

   out_commit_ctrl #(
      .SYNC_TIMEOUT (SYNC_TIMEOUT),
      .TO_W         (TO_W)
   ) u_ctrl (
      .clk            (clk),
      .rst            (rst),
      .i_cfg_valid    (cfg_valid),
      .i_sync         (sync),
      .o_cfg_ready    (cfg_ready),
      .o_shadow_load  (w_shadow_load),
      .o_commit       (w_commit),
      .o_commit_pulse (commit_pulse),
      .o_timeout_flag (timeout_flag)
   );

   // Shadow holds the offered config until commit; reset discards anything pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shd_sel <= '0;
         r_shd_inv <= '0;
      end else if (w_shadow_load) begin
         r_shd_sel <= cfg_sel_pwm;
         r_shd_inv <= cfg_invert;
      end
   end

   // Active config only changes on a commit, i.e. at a PWM period boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_act_sel <= '0;
         r_act_inv <= '0;
      end else if (w_commit) begin
         r_act_sel <= r_shd_sel;
         r_act_inv <= r_shd_inv;
      end
   end

   // Use the config that is active after this edge so opins switches in the commit cycle itself.
   assign w_sel = w_commit ? r_shd_sel : r_act_sel;
   assign w_inv = w_commit ? r_shd_inv : r_act_inv;
   assign w_mux = ((w_sel & pwm_dc) | (~w_sel & ovalues)) ^ w_inv;

`ifdef OUT_STAGE_FAULT_EN
   logic r_fault_active;
   logic w_fault_nxt;

   // Fault latch: set by fault, cleared by fault_clr only when fault is low.
   always_comb begin
      w_fault_nxt = r_fault_active;
      if (fault)          w_fault_nxt = 1'b1;
      else if (fault_clr) w_fault_nxt = 1'b0;
   end

   // Fault state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_fault_active <= 1'b0;
      else     r_fault_active <= w_fault_nxt;
   end

   // During a fault every pin sits at its deasserted level, which tracks committed inversion.
   assign w_opins_nxt  = w_fault_nxt ? w_inv : w_mux;
   assign fault_active = r_fault_active;
`else
   assign w_opins_nxt  = w_mux;
`endif

   // Registered pin drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_opins <= '0;
      else     r_opins <= w_opins_nxt;
   end

   assign opins = r_opins;

endmodule
